// File: rtl/prng_rand_dispenser.sv
// Purpose : buffers 64-bit Trivium PRNG words in a DEPTH-entry FIFO and serves
//           them as RAND_W-bit slices (LSB slice first) over valid/ready.
// Latency : a word pushed at edge k is visible on rand_out_o after edge k; reads
//           pop at the handshake edge. Backpressure: none upstream; a word that
//           arrives with the FIFO full and no pop that cycle is dropped.
//
// Ports   : clk_i, reset_i (async, active-high), flush_i (sync clear),
//           prng_valid_i/prng_word_i (producer), rand_ready_i/rand_valid_o/
//           rand_out_o (consumer), level_o (stored words), underflow_err_o
//           (sticky read-while-empty), drop_cnt_o (dropped-word count).
// Config  : `define PRNG_RAND_DROP_CNT_EN builds a saturating 16-bit drop
//           counter; when undefined, drop_cnt_o is tied to zero.
module prng_rand_dispenser #(
    parameter int RAND_W = 16,
    parameter int DEPTH  = 4
) (
    input  logic                       clk_i,
    input  logic                       reset_i,
    input  logic                       flush_i,
    input  logic                       prng_valid_i,
    input  logic [63:0]                prng_word_i,
    input  logic                       rand_ready_i,
    output logic                       rand_valid_o,
    output logic [RAND_W-1:0]          rand_out_o,
    output logic [$clog2(DEPTH):0]     level_o,
    output logic                       underflow_err_o,
    output logic [15:0]                drop_cnt_o
);

    localparam int NS = 64 / RAND_W;                 // slices per word
    localparam int SW = (NS > 1) ? $clog2(NS) : 1;   // slice index width
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [63:0]   mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [LW-1:0] level_q, level_d;
    logic [SW-1:0] sidx_q, sidx_d;
    logic          uf_q, uf_d;

    logic [63:0]   head_w;
    logic          hs, last_slice, pop, push;

    // Outputs depend only on registered state, never on rand_ready_i.
    assign head_w       = mem_q[rd_ptr_q];
    assign rand_valid_o = (level_q != '0);
    assign rand_out_o   = rand_valid_o ? RAND_W'(head_w >> (sidx_q * RAND_W)) : '0;
    assign level_o      = level_q;
    assign underflow_err_o = uf_q;

    assign hs         = rand_valid_o && rand_ready_i && !flush_i;
    assign last_slice = (sidx_q == SW'(NS - 1));
    assign pop        = hs && last_slice;
    // A full FIFO still accepts a word when the head word leaves this cycle.
    assign push       = prng_valid_i && !flush_i && ((level_q < LW'(DEPTH)) || pop);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        sidx_d   = sidx_q;
        uf_d     = uf_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
            sidx_d   = '0;
            uf_d     = 1'b0;
        end else begin
            if (rand_ready_i && !rand_valid_o) begin
                uf_d = 1'b1;
            end
            if (hs) begin
                sidx_d = last_slice ? '0 : sidx_q + 1'b1;
            end
            if (push) begin
                wr_ptr_d = wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            if (push && !pop) begin
                level_d = level_q + 1'b1;
            end else if (pop && !push) begin
                level_d = level_q - 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            sidx_q   <= '0;
            uf_q     <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            sidx_q   <= sidx_d;
            uf_q     <= uf_d;
        end
    end

    // Storage needs no reset: level_q gates every read of it.
    always_ff @(posedge clk_i) begin
        if (push) begin
            mem_q[wr_ptr_q] <= prng_word_i;
        end
    end

`ifdef PRNG_RAND_DROP_CNT_EN
    logic        drop;
    logic [15:0] drop_cnt_q, drop_cnt_d;

    // Words arriving during flush are discarded silently, not counted.
    assign drop = prng_valid_i && !flush_i && !push;

    always_comb begin
        drop_cnt_d = drop_cnt_q;
        if (flush_i) begin
            drop_cnt_d = '0;
        end else if (drop && (drop_cnt_q != 16'hFFFF)) begin
            drop_cnt_d = drop_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            drop_cnt_q <= '0;
        end else begin
            drop_cnt_q <= drop_cnt_d;
        end
    end

    assign drop_cnt_o = drop_cnt_q;
`else
    assign drop_cnt_o = 16'h0000;
`endif

endmodule

// File: doc/prng_rand_dispenser.md
# prng_rand_dispenser

Buffers 64-bit words from the Trivium PRNG and serves them to the masked AES datapath as RAND_W-bit slices over a valid/ready handshake. It sits directly downstream of the PRNG. The PRNG produces one word per cycle with no backpressure, so this block absorbs the rate mismatch: it holds up to DEPTH words, drops surplus words, and flags under-supply.

## Interface
- RAND_W, 16: slice width delivered per handshake; legal values are 8, 16, 32, 64.
- DEPTH, 4: number of 64-bit words held; power of two, ≥2.
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high; clears all state.
- flush  input  1  synchronous clear, pulsed alongside PRNG reseed.
- prng_valid  input  1  PRNG output valid; a level, high every cycle once warm.
- prng_word  input  64  PRNG output word.
- rand_ready  input  1  consumer takes the current slice.
- rand_valid  output  1  a slice is available; equals !empty.
- rand_out  output  RAND_W  current slice; all zeros when empty.
- level  output  $clog2(DEPTH)+1  number of words stored.
- underflow_err  output  1  sticky; set when rand_ready is high while rand_valid is low.
- drop_cnt  output  16  saturating count of discarded PRNG words (see Configuration).

## Operation
- FIFO with DEPTH entries; wr_ptr and rd_ptr are $clog2(DEPTH) bits and wrap modulo DEPTH. level counts 0..DEPTH.
- Slice index `sidx` ranges over 0..64/RAND_W-1. rand_out = head_word[sidx*RAND_W +: RAND_W], so the LSB slice is served first.
- Push: on prng_valid when (level<DEPTH) or a word pop happens in the same cycle. Otherwise the word is dropped and drop_cnt increments.
- Read handshake: rand_valid && rand_ready.
  - If sidx < last: sidx increments.
  - If sidx == last: sidx returns to 0 and the word is popped (rd_ptr+1, level-1).
- RAND_W=64: every handshake pops one word.
- Push and word pop in the same cycle: level is unchanged and both pointers advance.
- flush: pointers, level and sidx go to 0; underflow_err clears; drop_cnt clears.
  - An input word in the flush cycle is neither stored nor counted.
  - A read in the flush cycle has no effect.
- underflow_err is set on rand_ready && !rand_valid and holds until flush or reset. rand_out remains 0 in that case.
- No other state machine beyond the FIFO pointers and sidx.

## Timing
- Reset values: rand_valid=0, rand_out=0, level=0, underflow_err=0, drop_cnt=0; pointers and sidx are 0. Storage contents are don't-care.
- Write latency: a word pushed at edge k gives rand_valid=1 and an updated level after edge k.
- rand_out and rand_valid are combinational from registered state only. There is no path from rand_ready to rand_out within the same cycle.
- A slice is consumed at the edge where the handshake occurs. The next slice or word is visible after that edge.
- Full throughput: with RAND_W=64 and continuous prng_valid and rand_ready, the block sustains one slice per cycle and level stays constant.
- If reset is asserted mid-operation, all outputs go to their reset values immediately, without waiting for a clock edge.

## Configuration
- Macro: `PRNG_RAND_DROP_CNT_EN`.
- Defined: drop_cnt is a 16-bit counter that saturates at 16'hFFFF and increments on each dropped prng_valid word; flush clears it.
- Undefined: no counter logic is built and drop_cnt is tied to 16'h0000. Drop behaviour is otherwise identical.

## Test plan
- Reset release, prng_valid=0, rand_ready=0 → rand_valid=0, rand_out=0, level=0 over 10 cycles. Asserting reset asynchronously mid-stream returns all outputs to reset values before the next edge.
- RAND_W=16, push a single word 64'h0123_4567_89AB_CDEF, then rand_ready=1 for 4 cycles → slices 16'hCDEF, 16'h89AB, 16'h4567, 16'h0123 in order; then rand_valid=0 and level=0.
- DEPTH=4, prng_valid=1 for 6 cycles with words 1..6 and rand_ready=0 → level=4, words 5 and 6 dropped, drop_cnt=2 (0 with the macro undefined); reads return 1,2,3,4.
- Full FIFO, RAND_W=64, prng_valid and rand_ready both high → a push and a pop every cycle, level stays 4, drop_cnt unchanged, output sequence has no gaps.
- Empty FIFO, rand_ready=1 for 1 cycle → underflow_err=1 and it stays 1 across later valid traffic; a flush pulse clears it to 0.
- Flush in a cycle with prng_valid=1 and a pending read on level=3 → after the edge level=0, sidx=0, rand_valid=0, and the incoming word is neither stored nor counted.
